// File: rtl/mac_rx_pkg.sv
// Shared types and constants for the MAC receive frame controller.
package mac_rx_pkg;

    typedef enum logic [2:0] {
        ST_IFG,
        ST_IDLE,
        ST_PRE,
        ST_DATA,
        ST_EOF,
        ST_CHECK,
        ST_DROP
    } state_e;

    localparam int ERR_W = 3;

    localparam logic [ERR_W-1:0] ERR_OK    = 3'd0;
    localparam logic [ERR_W-1:0] ERR_SHORT = 3'd1;
    localparam logic [ERR_W-1:0] ERR_LONG  = 3'd2;
    localparam logic [ERR_W-1:0] ERR_CRC   = 3'd3;
    localparam logic [ERR_W-1:0] ERR_ADDR  = 3'd4;
    localparam logic [ERR_W-1:0] ERR_RXER  = 3'd5;
    localparam logic [ERR_W-1:0] ERR_OVF   = 3'd6;
    localparam logic [ERR_W-1:0] ERR_ALIGN = 3'd7;

    function automatic logic [3:0] pre_sym(input int dw);
        return (dw == 2) ? 4'h1 : 4'h5;
    endfunction

    function automatic logic [3:0] sfd_last(input int dw);
        return (dw == 2) ? 4'h3 : 4'hD;
    endfunction

endpackage

// File: rtl/mac_rx_sym_asm.sv
// Assembles LSB-first DW-bit symbols into bytes.
module mac_rx_sym_asm #(
    parameter int DW = 2
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] sym,
    output logic [7:0]    byte_d,
    output logic          done,
    output logic [1:0]    phase
);

    localparam logic [1:0] LAST = 2'(8 / DW - 1);

    logic [7:0] sr;

    // Newest symbol lands in the MSBs so the first one ends up in bit 0.
    assign byte_d = {sym, sr[7:DW]};
    assign done   = en && (phase == LAST);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sr    <= '0;
            phase <= '0;
        end else if (clr) begin
            sr    <= '0;
            phase <= '0;
        end else if (en) begin
            sr    <= byte_d;
            phase <= done ? 2'd0 : phase + 2'd1;
        end
    end

endmodule

// File: rtl/mac_rx_frame_ctrl.sv
// Receive frame controller: preamble hunt, byte streaming,
// length/IFG/alignment checks and per-frame commit or drop.
module mac_rx_frame_ctrl
    import mac_rx_pkg::*;
#(
    parameter int DW      = 2,
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int IFG_CYC = 48,
    parameter int LEN_W   = 12
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             ICrs_dv,
    input  logic             IRx_er,
    input  logic [DW-1:0]    IRx_d,
    output logic             Oaddr_en,
    output logic [7:0]       Oaddr_byte,
    input  logic             Iaddr_chk_err,
    output logic             OCRC_init,
    output logic             OCRC_en,
    output logic [7:0]       OCRC_byte,
    input  logic             ICRC_chk_err,
    output logic             OFifo_wr,
    output logic [7:0]       OFifo_data,
    output logic             OFifo_commit,
    output logic             OFifo_drop,
    input  logic             IFifo_full,
    output logic             OFrm_valid,
    output logic [ERR_W-1:0] OFrm_err,
    output logic [LEN_W-1:0] OFrm_len
);

    localparam logic [3:0]    PRE_W = pre_sym(DW);
    localparam logic [3:0]    SFD_W = sfd_last(DW);
    localparam logic [DW-1:0] PRE   = PRE_W[DW-1:0];
    localparam logic [DW-1:0] SFD   = SFD_W[DW-1:0];
    localparam int            IW    = $clog2(IFG_CYC + 1);

    state_e           state, state_n;
    logic [IW-1:0]    ifg, ifg_n;
    logic [LEN_W-1:0] len, len_n;
    logic [ERR_W-1:0] code_n;
    logic             fin, wr_n, init_n;
    logic             sym_clr, sym_en;
    logic             addr_chk;
    logic [7:0]       byte_d;
    logic             done;
    logic [1:0]       phase;

    mac_rx_sym_asm #(.DW(DW)) u_asm (
        .Clk    (Clk),
        .Reset  (Reset),
        .clr    (sym_clr),
        .en     (sym_en),
        .sym    (IRx_d),
        .byte_d (byte_d),
        .done   (done),
        .phase  (phase)
    );

    always_comb begin
        state_n = state;
        ifg_n   = '0;
        len_n   = len;
        code_n  = ERR_OK;
        fin     = 1'b0;
        wr_n    = 1'b0;
        init_n  = 1'b0;
        sym_clr = 1'b0;
        sym_en  = 1'b0;
        unique case (state)
            ST_IFG: begin
                if (!ICrs_dv) begin
                    ifg_n = ifg + 1'b1;
                    if (ifg_n == IW'(IFG_CYC)) begin
                        state_n = ST_IDLE;
                        ifg_n   = '0;
                    end
                end
            end
            ST_IDLE: begin
                len_n = '0;
                if (ICrs_dv && IRx_d == PRE)
                    state_n = ST_PRE;
            end
            ST_PRE: begin
                if (!ICrs_dv) begin
                    state_n = ST_IFG;
                end else if (IRx_d == SFD) begin
                    state_n = ST_DATA;
                    init_n  = 1'b1;
                    sym_clr = 1'b1;
                    len_n   = '0;
                end else if (IRx_d != PRE) begin
                    state_n = ST_DROP;
                    fin     = 1'b1;
                    code_n  = ERR_ALIGN;
                end
            end
            ST_DATA: begin
                sym_en = ICrs_dv;
                if (done)
                    len_n = len + 1'b1;
                // First matching cause wins; an erroring byte is never written.
                if (IRx_er) begin
                    state_n = ST_DROP;
                    fin     = 1'b1;
                    code_n  = ERR_RXER;
                end else if (done && IFifo_full) begin
                    state_n = ST_DROP;
                    fin     = 1'b1;
                    code_n  = ERR_OVF;
                end else if (addr_chk && Iaddr_chk_err) begin
                    state_n = ST_DROP;
                    fin     = 1'b1;
                    code_n  = ERR_ADDR;
                end else if (done && len >= LEN_W'(MAX_LEN)) begin
                    state_n = ST_DROP;
                    fin     = 1'b1;
                    code_n  = ERR_LONG;
                end else if (!ICrs_dv && phase != 2'd0) begin
                    state_n = ST_DROP;
                    fin     = 1'b1;
                    code_n  = ERR_ALIGN;
                end else if (!ICrs_dv) begin
                    state_n = ST_EOF;
                end else begin
                    wr_n = done;
                end
            end
            // Extra cycle so the CRC residue of the last byte has settled.
            ST_EOF: begin
                state_n = ST_CHECK;
            end
            ST_CHECK: begin
                state_n = ST_IFG;
                fin     = 1'b1;
                if (len < LEN_W'(MIN_LEN))
                    code_n = ERR_SHORT;
                else if (ICRC_chk_err)
                    code_n = ERR_CRC;
            end
            ST_DROP: begin
                if (!ICrs_dv)
                    state_n = ST_IFG;
            end
            default: state_n = ST_IFG;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state        <= ST_IFG;
            ifg          <= '0;
            len          <= '0;
            addr_chk     <= 1'b0;
            Oaddr_en     <= 1'b0;
            Oaddr_byte   <= '0;
            OCRC_init    <= 1'b0;
            OCRC_en      <= 1'b0;
            OCRC_byte    <= '0;
            OFifo_wr     <= 1'b0;
            OFifo_data   <= '0;
            OFifo_commit <= 1'b0;
            OFifo_drop   <= 1'b0;
            OFrm_valid   <= 1'b0;
            OFrm_err     <= '0;
            OFrm_len     <= '0;
        end else begin
            state        <= state_n;
            ifg          <= ifg_n;
            len          <= len_n;
            addr_chk     <= Oaddr_en && (len == LEN_W'(6));
            Oaddr_en     <= wr_n && (len < LEN_W'(6));
            OCRC_init    <= init_n;
            OCRC_en      <= wr_n;
            OFifo_wr     <= wr_n;
            if (wr_n) begin
                Oaddr_byte <= byte_d;
                OCRC_byte  <= byte_d;
                OFifo_data <= byte_d;
            end
            OFifo_commit <= fin && (code_n == ERR_OK);
            OFifo_drop   <= fin && (code_n != ERR_OK);
            OFrm_valid   <= fin;
            if (fin) begin
                OFrm_err <= code_n;
                OFrm_len <= len_n;
            end
        end
    end

endmodule

// File: tb/tb_mac_rx_frame_ctrl.sv
// Directed bench for mac_rx_frame_ctrl: one RMII (DW=2) and one MII (DW=4) instance.
module tb_mac_rx_frame_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       crs2 = 1'b0, crs4 = 1'b0, er = 1'b0;
    logic [1:0] d2 = '0;
    logic [3:0] d4 = '0;
    logic       aerr = 1'b0, cerr = 1'b0, full = 1'b0;

    logic        a2_en, i2, c2_en, w2, cm2, dp2, v2;
    logic [7:0]  a2_b, c2_b, w2_d;
    logic [2:0]  e2;
    logic [11:0] l2;
    logic        a4_en, i4, c4_en, w4, cm4, dp4, v4;
    logic [7:0]  a4_b, c4_b, w4_d;
    logic [2:0]  e4;
    logic [11:0] l4;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    mac_rx_frame_ctrl #(.DW(2)) u2 (
        .Clk(Clk), .Reset(Reset), .ICrs_dv(crs2), .IRx_er(er), .IRx_d(d2),
        .Oaddr_en(a2_en), .Oaddr_byte(a2_b), .Iaddr_chk_err(aerr),
        .OCRC_init(i2), .OCRC_en(c2_en), .OCRC_byte(c2_b), .ICRC_chk_err(cerr),
        .OFifo_wr(w2), .OFifo_data(w2_d), .OFifo_commit(cm2), .OFifo_drop(dp2),
        .IFifo_full(full), .OFrm_valid(v2), .OFrm_err(e2), .OFrm_len(l2)
    );

    mac_rx_frame_ctrl #(.DW(4)) u4 (
        .Clk(Clk), .Reset(Reset), .ICrs_dv(crs4), .IRx_er(er), .IRx_d(d4),
        .Oaddr_en(a4_en), .Oaddr_byte(a4_b), .Iaddr_chk_err(aerr),
        .OCRC_init(i4), .OCRC_en(c4_en), .OCRC_byte(c4_b), .ICRC_chk_err(cerr),
        .OFifo_wr(w4), .OFifo_data(w4_d), .OFifo_commit(cm4), .OFifo_drop(dp4),
        .IFifo_full(full), .OFrm_valid(v4), .OFrm_err(e4), .OFrm_len(l4)
    );

    int nwr2 = 0, ncm2 = 0, ndp2 = 0, nv2 = 0, na2 = 0, ni2 = 0;
    int nwr4 = 0, ncm4 = 0, ndp4 = 0, nv4 = 0, na4 = 0, ni4 = 0;
    logic [7:0] cap2[$];
    logic [7:0] cap4[$];

    always @(negedge Clk) begin
        if (w2) begin nwr2++; cap2.push_back(w2_d); end
        if (cm2) ncm2++;
        if (dp2) ndp2++;
        if (v2) nv2++;
        if (a2_en) na2++;
        if (i2) ni2++;
        if (w4) begin nwr4++; cap4.push_back(w4_d); end
        if (cm4) ncm4++;
        if (dp4) ndp4++;
        if (v4) nv4++;
        if (a4_en) na4++;
        if (i4) ni4++;
    end

    int bwr2, bcm2, bdp2, bv2, ba2, bi2, bc2;
    int bwr4, bcm4, bdp4, bv4, ba4, bi4, bc4;

    task automatic snap();
        bwr2 = nwr2; bcm2 = ncm2; bdp2 = ndp2; bv2 = nv2;
        ba2 = na2; bi2 = ni2; bc2 = cap2.size();
        bwr4 = nwr4; bcm4 = ncm4; bdp4 = ndp4; bv4 = nv4;
        ba4 = na4; bi4 = ni4; bc4 = cap4.size();
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 37 + 11);
    endfunction

    function automatic int nz2();
        return int'(|{a2_en, a2_b, i2, c2_en, c2_b, w2, w2_d,
                      cm2, dp2, v2, e2, l2});
    endfunction

    function automatic int nz4();
        return int'(|{a4_en, a4_b, i4, c4_en, c4_b, w4, w4_d,
                      cm4, dp4, v4, e4, l4});
    endfunction

    task automatic sym2(input logic [1:0] s);
        crs2 = 1'b1; d2 = s;
        @(posedge Clk); #1;
    endtask

    task automatic sym4(input logic [3:0] s);
        crs4 = 1'b1; d4 = s;
        @(posedge Clk); #1;
    endtask

    task automatic tx2(input logic [7:0] b);
        for (int k = 0; k < 4; k++) sym2(b[2*k +: 2]);
    endtask

    task automatic tx4(input logic [7:0] b);
        for (int k = 0; k < 2; k++) sym4(b[4*k +: 4]);
    endtask

    task automatic frame2(input int n);
        for (int k = 0; k < 7; k++) tx2(8'h55);
        tx2(8'hD5);
        for (int i = 0; i < n; i++) tx2(pat(i));
    endtask

    task automatic frame4(input int n);
        for (int k = 0; k < 7; k++) tx4(8'h55);
        tx4(8'hD5);
        for (int i = 0; i < n; i++) tx4(pat(i));
    endtask

    task automatic quiet(input int n);
        crs2 = 1'b0; crs4 = 1'b0; d2 = '0; d4 = '0;
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic chk_stat(input int dw, input string tag, input int wr,
                            input int cm, input int dp, input int err, input int len);
        int dwr, dcm, ddp, dv;
        dwr = (dw == 2) ? nwr2 - bwr2 : nwr4 - bwr4;
        dcm = (dw == 2) ? ncm2 - bcm2 : ncm4 - bcm4;
        ddp = (dw == 2) ? ndp2 - bdp2 : ndp4 - bdp4;
        dv  = (dw == 2) ? nv2 - bv2 : nv4 - bv4;
        chk({tag, " wr"}, dwr, wr);
        chk({tag, " commit"}, dcm, cm);
        chk({tag, " drop"}, ddp, dp);
        chk({tag, " valid"}, dv, cm + dp);
        chk({tag, " err"}, (dw == 2) ? int'(e2) : int'(e4), err);
        chk({tag, " len"}, (dw == 2) ? int'(l2) : int'(l4), len);
    endtask

    task automatic chk_data(input int dw, input string tag, input int base, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (dw == 2) begin
                if (base + i >= cap2.size() || cap2[base+i] !== pat(i)) bad++;
            end else begin
                if (base + i >= cap4.size() || cap4[base+i] !== pat(i)) bad++;
            end
        end
        chk(tag, bad, 0);
    endtask

    initial begin
        quiet(3);
        chk("reset outs u2", nz2(), 0);
        chk("reset outs u4", nz4(), 0);
        Reset = 1'b1;
        quiet(55);

        snap(); frame2(64); quiet(10);
        chk_stat(2, "good64", 64, 1, 0, 0, 64);
        chk("good64 addr_en", na2 - ba2, 6);
        chk("good64 crc_init", ni2 - bi2, 1);
        chk_data(2, "good64 data", bc2, 64);
        quiet(50);

        cerr = 1'b1;
        snap(); frame2(64); quiet(10);
        cerr = 1'b0;
        chk_stat(2, "crc", 64, 0, 1, 3, 64);
        quiet(50);

        aerr = 1'b1;
        snap(); frame2(20); quiet(10);
        aerr = 1'b0;
        chk_stat(2, "addr", 6, 0, 1, 4, 6);
        quiet(50);

        snap(); frame2(29);
        er = 1'b1; sym2(2'b00); er = 1'b0;
        for (int i = 0; i < 5; i++) tx2(8'h00);
        quiet(10);
        chk_stat(2, "rxer", 29, 0, 1, 5, 29);
        quiet(50);

        snap(); frame2(70); sym2(2'b10); sym2(2'b01); quiet(10);
        chk_stat(2, "align", 70, 0, 1, 7, 70);
        snap(); frame2(64); quiet(10);
        chk("ifg ignored wr", nwr2 - bwr2, 0);
        chk("ifg ignored valid", nv2 - bv2, 0);
        quiet(50);
        snap(); frame2(64); quiet(10);
        chk_stat(2, "after ifg", 64, 1, 0, 0, 64);
        quiet(50);

        snap();
        for (int k = 0; k < 5; k++) tx2(8'h55);
        quiet(10);
        chk("pre abort valid", nv2 - bv2, 0);
        chk("pre abort drop", ndp2 - bdp2, 0);
        quiet(50);

        snap(); frame4(60); quiet(10);
        chk_stat(4, "short", 60, 0, 1, 1, 60);
        chk_data(4, "short data", bc4, 60);
        quiet(50);

        snap(); sym4(4'h5); sym4(4'h5); sym4(4'h5); sym4(4'h3); sym4(4'h5);
        quiet(10);
        chk_stat(4, "bad sfd", 0, 0, 1, 7, 0);
        quiet(50);

        snap(); frame4(64); quiet(10);
        chk_stat(4, "min64", 64, 1, 0, 0, 64);
        quiet(50);

        snap(); frame4(1518); quiet(10);
        chk_stat(4, "max1518", 1518, 1, 0, 0, 1518);
        quiet(50);

        snap(); frame4(1525); quiet(10);
        chk_stat(4, "long", 1518, 0, 1, 2, 1519);
        quiet(50);

        snap(); frame4(99);
        full = 1'b1;
        for (int i = 0; i < 10; i++) tx4(pat(i));
        quiet(10);
        full = 1'b0;
        chk_stat(4, "overflow", 99, 0, 1, 6, 100);
        quiet(50);

        snap(); frame2(20); sym2(2'b00);
        Reset = 1'b0;
        @(negedge Clk);
        chk("midrst outs", nz2(), 0);
        @(posedge Clk); #1;
        for (int i = 0; i < 5; i++) tx2(pat(i));
        Reset = 1'b1;
        for (int i = 0; i < 30; i++) tx2(pat(i));
        quiet(10);
        chk("midrst wr", nwr2 - bwr2, 20);
        chk("midrst valid", nv2 - bv2, 0);
        chk("midrst commit+drop", (ncm2 - bcm2) + (ndp2 - bdp2), 0);
        quiet(50);
        snap(); frame2(64); quiet(10);
        chk_stat(2, "post reset", 64, 1, 0, 0, 64);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mac_rx_frame_ctrl.md
# mac_rx_frame_ctrl

Parametrised receive-side frame controller for the MAC, sitting between the MII/RMII PHY pins and the address checker, CRC checker and receive FIFO. It assembles DW-bit symbols into bytes and hunts preamble/SFD. It streams frame bytes to the checkers and FIFO, enforces length, IFG, alignment and error rules, and ends every frame with exactly one commit or drop plus a status pulse. It is the next generation of the fixed-width RMII receive FSM, adding MII width, programmable limits, FIFO back-pressure handling and coded frame status.

## Interface
Parameters:
- DW, 2: symbol width; 2 = RMII, 4 = MII. Only 2 and 4 are legal.
- MIN_LEN, 64: minimum frame bytes after the SFD, FCS included.
- MAX_LEN, 1518: maximum frame bytes after the SFD, FCS included.
- IFG_CYC, 48: consecutive ICrs_dv-low cycles required before re-arming.
- LEN_W, 12: length counter width.

Ports:
- Clk  in  1  receive clock, one symbol per cycle.
- Reset  in  1  asynchronous, active-low reset.
- ICrs_dv  in  1  carrier sense / data valid.
- IRx_er  in  1  PHY receive error.
- IRx_d  in  DW  receive symbol, LSB first on the wire.
- Oaddr_en  out  1  strobe for frame bytes 0..5.
- Oaddr_byte  out  8  byte presented to the address checker.
- Iaddr_chk_err  in  1  address mismatch, valid one cycle after the 6th Oaddr_en.
- OCRC_init  out  1  CRC reset pulse.
- OCRC_en  out  1  CRC byte strobe.
- OCRC_byte  out  8  byte presented to the CRC checker.
- ICRC_chk_err  in  1  CRC residue mismatch, valid one cycle after the last OCRC_en.
- OFifo_wr  out  1  FIFO write strobe.
- OFifo_data  out  8  FIFO write data.
- OFifo_commit  out  1  pulse: keep the frame written since the last commit/drop.
- OFifo_drop  out  1  pulse: discard the frame written since the last commit/drop.
- IFifo_full  in  1  FIFO cannot accept a write.
- OFrm_valid  out  1  one-cycle status pulse.
- OFrm_err  out  3  status code: 0 ok, 1 short, 2 long, 3 CRC, 4 address, 5 rx_er, 6 overflow, 7 alignment.
- OFrm_len  out  LEN_W  byte count, saturating at MAX_LEN+1.

## Operation
- Symbol constants: PRE = DW LSBs of 8'h55; SFD_LAST = 2'b11 for DW=2, 4'hD for DW=4.
- States and transitions:
  - IFG: count ICrs_dv-low cycles; any high cycle restarts the count. Reaching IFG_CYC moves to IDLE.
  - IDLE: on ICrs_dv=1 with IRx_d==PRE, move to PREAMBLE.
  - PREAMBLE:
    - ICrs_dv=0: move to IFG silently, with no status.
    - PRE: stay.
    - SFD_LAST: move to DATA; pulse OCRC_init; clear phase and length.
    - Any other symbol: move to DROP, code 7.
  - DATA: a byte completes every 8/DW symbols. On completion, length increments and OFifo_wr and OCRC_en pulse. Bytes 0..5 also pulse Oaddr_en. Exit rules, first match wins:
    - IRx_er: code 5.
    - Write attempted while IFifo_full: code 6; that byte is not written.
    - Iaddr_chk_err: code 4.
    - Length > MAX_LEN: code 2.
    - ICrs_dv=0 with phase ≠ 0: code 7.
    - ICrs_dv=0 with phase 0: move to CHECK.
    - Every code above moves to DROP.
  - CHECK: lasts one cycle and decides in priority order:
    - Length < MIN_LEN: code 1.
    - ICRC_chk_err: code 3.
    - Otherwise: code 0.
    - Code 0 pulses OFifo_commit; any other code pulses OFifo_drop. Either way, pulse OFrm_valid and move to IFG.
  - DROP: on entry, pulse OFifo_drop and OFrm_valid with the code. Then wait for ICrs_dv=0 and move to IFG. Writes are suppressed while in DROP.
- Length counts every byte after the SFD, including the FCS.

## Timing
- Reset value of every output is 0. Reset state is IFG with the counter cleared, so a frame already in progress is never captured.
- Byte strobes (Oaddr_en, OCRC_en, OFifo_wr) and their data are registered, one cycle after the byte's last symbol is sampled.
- OCRC_init is asserted in the cycle after the SFD symbol.
- CHECK is entered no earlier than 2 cycles after the last OCRC_en.
- OFrm_valid is asserted in the same cycle as OFifo_commit or OFifo_drop; OFrm_err and OFrm_len hold until the next OFrm_valid.
- Exactly one commit or drop per frame that passes the SFD. None for a frame aborted in PREAMBLE.
- An error and CRS loss in the same cycle: the error code wins.
- Reset asserted mid-frame: no commit or drop is emitted; the FIFO clears its pending frame on its own reset.

## Structure
- Package mac_rx_pkg holds:
  - the state enum;
  - error-code localparams;
  - PRE and SFD_LAST as functions of DW;
  - the status-code width.
- Sub-module mac_rx_sym_asm holds the DW-to-byte shift register, phase counter and byte-done strobe, with a sync clear on SFD.

## Test plan
- DW=2, 64-byte good frame with 7×55 + D5 preamble/SFD and CRC ok → 64 OFifo_wr, one OFifo_commit, OFrm_err=0, OFrm_len=64.
- DW=4, 60-byte frame → OFifo_drop, OFrm_err=1, OFrm_len=60. A 1519-byte frame → drop with code 2 when length reaches 1519.
- Iaddr_chk_err=1 after byte 6 → drop, code 4. Bytes 7 onward are not written; OFrm_valid pulses once.
- IFifo_full raised at byte 100 → drop, code 6. IRx_er pulsed at byte 30 → drop, code 5.
- DW=2, CRS drops with phase=2 → code 7. Second frame starts 10 cycles after CRS drops → ignored until 48 quiet cycles have passed.
- Reset asserted mid-DATA → all outputs 0 next cycle. No capture until CRS stays low for IFG_CYC cycles.
